// File: rtl/lwb_pkg.sv
// Shared types for the load/writeback unit: FSM state encoding, RV64 load funct3 codes
// and the access-size alignment helper.
package lwb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_WB
   } lwb_state_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;
   localparam logic [2:0] F3_INV = 3'b111;

   // funct3[1:0] encodes log2 of the access size in bytes.
   function automatic logic lwb_misaligned(input logic [2:0] funct3, input logic [2:0] off);
      logic mis;
      case (funct3[1:0])
         2'b00:   mis = 1'b0;
         2'b01:   mis = off[0];
         2'b10:   mis = |off[1:0];
         default: mis = |off;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational byte-lane extraction: shift the doubleword down to the addressed byte,
// then sign- or zero-extend the accessed width to 64 bits.
module load_extract
   import lwb_pkg::*;
(
   input  logic [63:0] rdata_i,
   input  logic [2:0]  offset_i,
   input  logic [2:0]  funct3_i,
   output logic [63:0] data_o
);

   logic [63:0] shifted;

   // Bytes past the end of the doubleword shift in as zero.
   assign shifted = rdata_i >> {offset_i, 3'b000};

   always_comb begin
      data_o = '0;
      case (funct3_i)
         F3_LB:   data_o = {{56{shifted[7]}},  shifted[7:0]};
         F3_LH:   data_o = {{48{shifted[15]}}, shifted[15:0]};
         F3_LW:   data_o = {{32{shifted[31]}}, shifted[31:0]};
         F3_LD:   data_o = shifted;
         F3_LBU:  data_o = {56'd0, shifted[7:0]};
         F3_LHU:  data_o = {48'd0, shifted[15:0]};
         F3_LWU:  data_o = {32'd0, shifted[31:0]};
         default: data_o = '0;
      endcase
   end

endmodule

// File: rtl/load_writeback_unit.sv
// RV64 load unit: IDLE -> REQ -> WAIT -> WB with memory timeout and register writeback.
// Define LWB_MISALIGN_TRAP_EN to abort loads not aligned to their access size.
module load_writeback_unit
   import lwb_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        issue_valid,
   output logic        issue_ready,
   input  logic [4:0]  issue_rd,
   input  logic [2:0]  issue_funct3,
   input  logic [63:0] issue_addr,
   output logic        mem_req,
   output logic [63:0] mem_addr,
   input  logic        mem_ready,
   input  logic        mem_rvalid,
   input  logic [63:0] mem_rdata,
   output logic [4:0]  rd,
   output logic        regWrite,
   output logic [63:0] writeData,
   output logic        err
);

   localparam int unsigned CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

   lwb_state_e  state_q;
   logic [4:0]  ld_rd_q;
   logic [2:0]  ld_funct3_q;
   logic [2:0]  ld_off_q;
   logic        abort_q;
   logic [CW-1:0] cnt_q;

   logic        ready_q;
   logic        mem_req_q;
   logic [63:0] mem_addr_q;
   logic [4:0]  rd_q;
   logic        reg_write_q;
   logic [63:0] write_data_q;
   logic        err_q;

   logic        abort_d;
   logic [63:0] ext_data_d;

   load_extract u_extract (
      .rdata_i  (mem_rdata),
      .offset_i (ld_off_q),
      .funct3_i (ld_funct3_q),
      .data_o   (ext_data_d)
   );

   always_comb begin
`ifdef LWB_MISALIGN_TRAP_EN
      abort_d = (issue_funct3 == F3_INV) || lwb_misaligned(issue_funct3, issue_addr[2:0]);
`else
      abort_d = (issue_funct3 == F3_INV);
`endif
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         ld_rd_q      <= '0;
         ld_funct3_q  <= '0;
         ld_off_q     <= '0;
         abort_q      <= 1'b0;
         cnt_q        <= '0;
         ready_q      <= 1'b1;
         mem_req_q    <= 1'b0;
         mem_addr_q   <= '0;
         rd_q         <= '0;
         reg_write_q  <= 1'b0;
         write_data_q <= '0;
         err_q        <= 1'b0;
      end else begin
         err_q        <= 1'b0;
         reg_write_q  <= 1'b0;
         rd_q         <= '0;
         write_data_q <= '0;
         case (state_q)
            ST_IDLE: begin
               if (issue_valid) begin
                  ld_rd_q     <= issue_rd;
                  ld_funct3_q <= issue_funct3;
                  ld_off_q    <= issue_addr[2:0];
                  abort_q     <= abort_d;
                  ready_q     <= 1'b0;
                  state_q     <= ST_REQ;
                  // Aborted loads still pass through REQ but never raise mem_req.
                  if (!abort_d) begin
                     mem_req_q  <= 1'b1;
                     mem_addr_q <= {issue_addr[63:3], 3'b000};
                  end
               end
            end
            ST_REQ: begin
               if (abort_q) begin
                  err_q   <= 1'b1;
                  ready_q <= 1'b1;
                  state_q <= ST_IDLE;
               end else if (mem_ready) begin
                  mem_req_q  <= 1'b0;
                  mem_addr_q <= '0;
                  cnt_q      <= '0;
                  state_q    <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (mem_rvalid) begin
                  rd_q         <= ld_rd_q;
                  reg_write_q  <= (ld_rd_q != 5'd0);
                  write_data_q <= ext_data_d;
                  cnt_q        <= '0;
                  state_q      <= ST_WB;
               end else if (cnt_q == CW'(MEM_TIMEOUT - 1)) begin
                  err_q   <= 1'b1;
                  ready_q <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_WB: begin
               ready_q <= 1'b1;
               state_q <= ST_IDLE;
            end
            default: begin
               ready_q <= 1'b1;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign issue_ready = ready_q;
   assign mem_req     = mem_req_q;
   assign mem_addr    = mem_addr_q;
   assign rd          = rd_q;
   assign regWrite    = reg_write_q;
   assign writeData   = write_data_q;
   assign err         = err_q;

endmodule

// File: tb/tb_load_writeback_unit.sv
// Self-checking bench for load_writeback_unit: directed vectors plus randomized loads
// compared against a cycle-timeline reference model.
module tb_load_writeback_unit;

   localparam int unsigned TO = 16;

   logic        clock = 1'b0;
   logic        reset;
   logic        issue_valid;
   logic        issue_ready;
   logic [4:0]  issue_rd;
   logic [2:0]  issue_funct3;
   logic [63:0] issue_addr;
   logic        mem_req;
   logic [63:0] mem_addr;
   logic        mem_ready;
   logic        mem_rvalid;
   logic [63:0] mem_rdata;
   logic [4:0]  rd;
   logic        regWrite;
   logic [63:0] writeData;
   logic        err;

   int unsigned checks = 0;
   int unsigned errors = 0;

   load_writeback_unit #(.MEM_TIMEOUT(TO)) dut (
      .clock        (clock),
      .reset        (reset),
      .issue_valid  (issue_valid),
      .issue_ready  (issue_ready),
      .issue_rd     (issue_rd),
      .issue_funct3 (issue_funct3),
      .issue_addr   (issue_addr),
      .mem_req      (mem_req),
      .mem_addr     (mem_addr),
      .mem_ready    (mem_ready),
      .mem_rvalid   (mem_rvalid),
      .mem_rdata    (mem_rdata),
      .rd           (rd),
      .regWrite     (regWrite),
      .writeData    (writeData),
      .err          (err)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic int unsigned access_bytes(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   // Reference load value: gather bytes one by one, treat bytes past byte 7 as zero.
   function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [63:0] addr,
                                           input logic [63:0] data);
      int unsigned n;
      int unsigned off;
      logic [63:0] val;
      logic [63:0] b;
      n   = access_bytes(f3);
      off = int'(addr % 8);
      val = '0;
      for (int unsigned i = 0; i < n; i++) begin
         if (off + i < 8) begin
            b   = (data / (64'd1 << (8 * (off + i)))) % 256;
            val = val + (b << (8 * i));
         end
      end
      if (f3 < 3'd3 && val >= (64'd1 << (8 * n - 1)))
         val = val - (64'd1 << (8 * n));
      return val;
   endfunction

   function automatic bit ref_abort(input logic [2:0] f3, input logic [63:0] addr);
      bit a;
      a = (f3 == 3'b111);
`ifdef LWB_MISALIGN_TRAP_EN
      if (!a && (addr % access_bytes(f3)) != 0) a = 1'b1;
`endif
      return a;
   endfunction

   task automatic check_idle_outputs(input string tag);
      check({tag, "_ready"},  issue_ready, 1'b1);
      check({tag, "_memreq"}, mem_req,     1'b0);
      check({tag, "_regwr"},  regWrite,    1'b0);
      check({tag, "_rd"},     rd,          5'd0);
      check({tag, "_wdata"},  writeData,   64'd0);
   endtask

   // Drives one load and checks every cycle of its expected timeline.
   task automatic run_load(input logic [4:0] r, input logic [2:0] f3, input logic [63:0] a,
                           input logic [63:0] data, input int unsigned rdy_dly,
                           input int unsigned rv_dly, input bit timeout);
      logic [63:0] exp_addr;
      bit          abort;
      exp_addr = a - (a % 8);
      abort    = ref_abort(f3, a);

      check("issue_ready", issue_ready, 1'b1);
      issue_valid  = 1'b1;
      issue_rd     = r;
      issue_funct3 = f3;
      issue_addr   = a;
      mem_ready    = 1'b0;
      mem_rvalid   = 1'b0;
      tick();
      issue_valid  = 1'($urandom_range(1));
      issue_rd     = 5'($urandom);
      issue_funct3 = 3'($urandom);
      issue_addr   = {$urandom, $urandom};

      if (abort) begin
         check("abort_memreq", mem_req, 1'b0);
         check("abort_busy", issue_ready, 1'b0);
         check("abort_noerr_yet", err, 1'b0);
         mem_rvalid = 1'($urandom_range(1));
         tick();
         issue_valid = 1'b0;
         mem_rvalid  = 1'b0;
         check("abort_err", err, 1'b1);
         check("abort_memreq2", mem_req, 1'b0);
         check("abort_regwr", regWrite, 1'b0);
         check("abort_ready", issue_ready, 1'b1);
         tick();
         check("abort_err_pulse", err, 1'b0);
         return;
      end

      for (int unsigned i = 0; i <= rdy_dly; i++) begin
         check("req_memreq", mem_req, 1'b1);
         check("req_memaddr", mem_addr, exp_addr);
         check("req_busy", issue_ready, 1'b0);
         check("req_regwr", regWrite, 1'b0);
         mem_ready   = (i == rdy_dly);
         mem_rvalid  = 1'($urandom_range(1));
         mem_rdata   = {$urandom, $urandom};
         issue_valid = 1'($urandom_range(1));
         tick();
      end
      mem_ready = 1'b0;

      for (int unsigned i = 0; i < (timeout ? TO : rv_dly + 1); i++) begin
         check("wait_memreq", mem_req, 1'b0);
         check("wait_regwr", regWrite, 1'b0);
         check("wait_busy", issue_ready, 1'b0);
         check("wait_err", err, 1'b0);
         mem_rvalid  = !timeout && (i == rv_dly);
         mem_rdata   = mem_rvalid ? data : {$urandom, $urandom};
         issue_valid = 1'($urandom_range(1));
         tick();
      end
      mem_rvalid  = 1'b0;
      issue_valid = 1'b0;

      if (timeout) begin
         check("to_err", err, 1'b1);
         check("to_regwr", regWrite, 1'b0);
         check("to_ready", issue_ready, 1'b1);
         mem_rvalid = 1'b1;
         mem_rdata  = {$urandom, $urandom};
         tick();
         mem_rvalid = 1'b0;
         check("to_err_pulse", err, 1'b0);
         check("stale_regwr", regWrite, 1'b0);
         tick();
         check("stale_regwr2", regWrite, 1'b0);
         check("stale_ready", issue_ready, 1'b1);
         return;
      end

      check("wb_regwr", regWrite, (r != 5'd0));
      check("wb_busy", issue_ready, 1'b0);
      check("wb_err", err, 1'b0);
      if (r != 5'd0) begin
         check("wb_rd", rd, r);
         check("wb_wdata", writeData, ref_load(f3, a, data));
      end
      tick();
      check_idle_outputs("post_wb");
   endtask

   initial begin
      reset        = 1'b1;
      issue_valid  = 1'b0;
      issue_rd     = '0;
      issue_funct3 = '0;
      issue_addr   = '0;
      mem_ready    = 1'b0;
      mem_rvalid   = 1'b0;
      mem_rdata    = '0;
      tick();
      tick();
      check_idle_outputs("reset");
      check("reset_memaddr", mem_addr, 64'd0);
      check("reset_err", err, 1'b0);
      reset = 1'b0;
      tick();

      run_load(5'd5, 3'b000, 64'h1003, 64'h0000_0000_8000_0000, 0, 0, 0);
      run_load(5'd7, 3'b110, 64'h1004, 64'hDEAD_BEEF_0000_0000, 0, 0, 0);
      run_load(5'd0, 3'b011, 64'h2000, 64'h1234, 0, 0, 0);
      run_load(5'd9, 3'b011, 64'h3008, 64'h0123_4567_89AB_CDEF, 5, 2, 0);
      run_load(5'd3, 3'b010, 64'h4000, 64'h0, 0, 0, 1);
      run_load(5'd4, 3'b111, 64'h5000, 64'h0, 0, 0, 0);
      run_load(5'd6, 3'b001, 64'h1001, 64'hA5A5_5A5A_F00D_8123, 1, 1, 0);
      run_load(5'd8, 3'b011, 64'h1003, 64'hFFEE_DDCC_BBAA_9988, 0, TO - 1, 0);

      // Reset while the load is waiting for data.
      issue_valid  = 1'b1;
      issue_rd     = 5'd12;
      issue_funct3 = 3'b011;
      issue_addr   = 64'h6000;
      mem_ready    = 1'b1;
      tick();
      issue_valid = 1'b0;
      tick();
      mem_ready = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_idle_outputs("rst_wait");
      check("rst_wait_err", err, 1'b0);
      mem_rvalid = 1'b1;
      mem_rdata  = 64'h1111_2222_3333_4444;
      tick();
      mem_rvalid = 1'b0;
      check("rst_stale_regwr", regWrite, 1'b0);
      tick();
      check_idle_outputs("rst_after");

      for (int unsigned t = 0; t < 80; t++) begin
         logic [4:0]  r;
         logic [2:0]  f3;
         logic [63:0] a;
         r  = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
         f3 = 3'($urandom);
         a  = {$urandom, $urandom};
         run_load(r, f3, a, {$urandom, $urandom}, $urandom_range(3),
                  $urandom_range(TO - 1), ($urandom_range(9) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/load_writeback_unit.md
LOAD_WRITEBACK_UNIT -- requirements
Module: load_writeback_unit

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16: WAIT-state cycles allowed before a load is aborted with an error.
REQ-002 SHALL have clock  input  1  the single clock, rising-edge active.
REQ-003 SHALL have reset  input  1  synchronous, active-high reset, sampled only on the rising edge of clock.
REQ-004 SHALL have issue_valid  input  1  load request present.
REQ-005 SHALL have issue_ready  output  1  unit can accept a load request.
REQ-006 SHALL have issue_rd  input  5  destination register index.
REQ-007 SHALL have issue_funct3  input  3  RV64 load type: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu.
REQ-008 SHALL have issue_addr  input  64  byte address of the load.
REQ-009 SHALL have mem_req, mem_addr[63:0], mem_ready  output, output, input  memory request handshake; mem_addr is doubleword-aligned.
REQ-010 SHALL have mem_rvalid, mem_rdata[63:0]  input, input  memory read response.
REQ-011 SHALL have rd[4:0], regWrite, writeData[63:0]  output  register-bank write port.
REQ-012 SHALL have err  output  1  one-cycle pulse when a load is aborted.

Function
REQ-013 SHALL implement the FSM IDLE -> REQ -> WAIT -> WB -> IDLE.
REQ-014 In IDLE, SHALL assert issue_ready=1 and, when issue_valid=1, latch rd, funct3 and addr, then go to REQ.
REQ-015 In REQ, SHALL drive mem_req=1 and mem_addr={addr[63:3],3'b000} and hold both stable until mem_ready=1, then go to WAIT.
REQ-016 In WAIT, SHALL sample mem_rvalid only in this state, latch the extracted data on mem_rvalid=1 and go to WB; mem_rvalid in any other state SHALL be ignored.
REQ-017 Extraction SHALL shift mem_rdata right by 8*addr[2:0], then sign- or zero-extend the low 8/16/32/64 bits per funct3 to 64 bits.
REQ-018 In WB, SHALL assert regWrite for exactly one cycle with the latched rd and writeData, then return to IDLE.
REQ-019 When rd==0, SHALL keep regWrite=0 in WB while still spending the WB cycle.
REQ-020 Latency SHALL be: issue accepted in cycle N, mem_req in N+1; with mem_ready in N+1 and mem_rvalid in N+2, regWrite=1 in N+3.
REQ-021 Outside WB, SHALL drive regWrite=0, rd=0 and writeData=0.
REQ-022 funct3=111 SHALL cause no memory request and a return from REQ to IDLE, with err=1 for one cycle.
REQ-023 The WAIT counter SHALL reset on entry to WAIT; after MEM_TIMEOUT cycles without mem_rvalid, the FSM SHALL return to IDLE with err=1 and no write.
REQ-024 issue_ready SHALL be 0 in REQ, WAIT and WB; issue_valid in those states SHALL be ignored.

Reset
REQ-025 While reset=1, SHALL force state=IDLE, issue_ready=1 and drive 0 on mem_req, mem_addr, regWrite, rd, writeData, err and the timeout counter.
REQ-026 Reset mid-operation SHALL abandon the in-flight load with no write, and a later stale mem_rvalid SHALL be ignored.

Configuration
REQ-027 With LWB_MISALIGN_TRAP_EN defined, a load whose address is not aligned to its access size SHALL make no memory request, perform no write, and pulse err=1 for one cycle.
REQ-028 Without LWB_MISALIGN_TRAP_EN, misaligned loads SHALL proceed, with bytes beyond the doubleword reading as zero before extension.

Structure
REQ-029 Package lwb_pkg SHALL hold the FSM state enum and the funct3 load-type constants.
REQ-030 The combinational shift/extend logic SHALL be the sub-module load_extract.

Verification
REQ-031 lb, addr=0x1003, rdata=0x0000_0000_8000_0000, rd=5 -> writeData=0xFFFF_FFFF_FFFF_FF80, regWrite in N+3.
REQ-032 lwu, addr=0x1004, rdata=0xDEAD_BEEF_0000_0000, rd=7 -> writeData=0x0000_0000_DEAD_BEEF, mem_addr=0x1000.
REQ-033 ld, rd=0, rdata=0x1234 -> no regWrite pulse, WB cycle still occupied, issue_ready back to 1 the cycle after.
REQ-034 mem_ready held 0 for 5 cycles -> mem_req and mem_addr held stable for 5 cycles, completion delayed by 5 cycles.
REQ-035 No mem_rvalid for 16 cycles -> err pulse, no regWrite; a mem_rvalid arriving afterwards is ignored.
REQ-036 lh at addr=0x1001 -> with LWB_MISALIGN_TRAP_EN: err pulse, mem_req never asserted; without: a write occurs. Reset asserted in WAIT -> IDLE next cycle, all outputs 0.
